// File: rtl/par_to_ser_unloader_pkg.sv
// Shared types and defaults for the circular buffer and its serial unloader.
// Group width constants here must match the buffer's read-side J.
package par_to_ser_unloader_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_J     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Bit offset of word slot idx inside a packed group; slot 0 is the LSBs.
  function automatic int slot_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/par_to_ser_unloader_if.sv
// Buffer read side plus serial valid/ready side of the unloader.
// master = unloader, slave = buffer/downstream (or a testbench driving both).
interface par_to_ser_unloader_if
  import par_to_ser_unloader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int J     = DEF_J
);
  logic                 buf_empty;
  logic                 buf_valid;
  logic [WIDTH*J-1:0]   buf_data;
  logic                 buf_r_en;
  logic [WIDTH-1:0]     ser_data;
  logic                 ser_valid;
  logic                 ser_ready;
  logic                 ser_last;

  modport master (
    input  buf_empty, buf_valid, buf_data, ser_ready,
    output buf_r_en, ser_data, ser_valid, ser_last
  );

  modport slave (
    output buf_empty, buf_valid, buf_data, ser_ready,
    input  buf_r_en, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/par_to_ser_unloader_par_shift_hold.sv
// J-word hold register with word index mux; load captures a group, advance steps to next slot.
// Output word and last flag are combinational from registered hold/index.
module par_shift_hold
  import par_to_ser_unloader_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  J     = DEF_J,
  localparam int IDX_W = (J > 1) ? $clog2(J) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [WIDTH*J-1:0] load_data,
  output logic [IDX_W-1:0]   idx,
  output logic [WIDTH-1:0]   data,
  output logic               last
);
  logic [WIDTH*J-1:0] hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      idx  <= '0;
    end else if (load) begin
      hold <= load_data;
      idx  <= '0;
    end else if (advance) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  assign data = hold[slot_lsb(int'(idx), WIDTH) +: WIDTH];
  assign last = (idx == IDX_W'(J - 1));
endmodule

// File: rtl/par_to_ser_unloader.sv
// Pulls one J-word group from the buffer and streams it out LSB slot first, one word per cycle.
// First word valid 1 cycle after buf_valid; words hold while ser_ready is low; next group requested on the last transfer.
module par_to_ser_unloader
  import par_to_ser_unloader_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int J       = DEF_J,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  par_to_ser_unloader_if.master bus,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     words_out
);
  localparam int IDX_W = (J > 1) ? $clog2(J) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               err_nxt;
  logic               r_en;
  logic               load, advance;
  logic               ser_vld;
  logic               xfer;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   word;
  logic               grp_last;

  par_shift_hold #(.WIDTH(WIDTH), .J(J)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (advance),
    .load_data(bus.buf_data),
    .idx      (idx),
    .data     (word),
    .last     (grp_last)
  );

  assign ser_vld = (state == ST_SHIFT);
  assign xfer    = ser_vld && bus.ser_ready;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_nxt   = err_timeout;
    r_en      = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.buf_empty) begin
          r_en      = 1'b1;
          timer_nxt = '0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_nxt = timer + 1'b1;
        // Data arriving on the expiry cycle still wins over the timeout.
        if (bus.buf_valid) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          advance = 1'b1;
          if (grp_last) begin
            if (!bus.buf_empty) begin
              r_en      = 1'b1;
              timer_nxt = '0;
              state_nxt = ST_WAIT;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      err_timeout <= 1'b0;
      words_out   <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      err_timeout <= err_nxt;
      if (xfer)
        words_out <= words_out + 1'b1;
    end
  end

  // The request is combinational from IDLE, so it is masked while reset is held.
  assign bus.buf_r_en  = r_en && rst;
  assign bus.ser_valid = ser_vld;
  assign bus.ser_data  = ser_vld ? word : '0;
  assign bus.ser_last  = ser_vld && (idx == IDX_W'(J - 1));
endmodule

// File: tb/tb_par_to_ser_unloader.sv
// Bench for par_to_ser_unloader: a queue-based buffer model feeds groups, the serial side is logged
// and compared against the word stream the groups should produce.
module tb_par_to_ser_unloader;
  localparam int WIDTH = 8, J = 4, TIMEOUT = 16, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             busy, err_timeout;
  logic [CNT_W-1:0] words_out;

  par_to_ser_unloader_if #(.WIDTH(WIDTH), .J(J)) bus_if ();

  par_to_ser_unloader #(.WIDTH(WIDTH), .J(J), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .busy       (busy),
    .err_timeout(err_timeout),
    .words_out  (words_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  logic [WIDTH*J-1:0] grp_q[$];
  logic [WIDTH*J-1:0] pend_data, stray_data;
  bit                 respond, stray_valid;
  int                 lat, pend, rdy_mode;
  bit                 rdy_q[$];
  logic [WIDTH-1:0]   got_q[$];
  logic [WIDTH-1:0]   exp_q[$];
  bit                 got_last[$];
  int                 xfer_cyc[$];
  int cyc, rd_pulses, rd_consec, rd_while_empty, rd_on_last, stall_changes;
  int last_ren_cyc, first_valid_cyc, err_rise_cyc;
  bit prev_ren, prev_stall, prev_last, prev_err;
  logic [WIDTH-1:0] prev_data;

  function automatic void clear_log();
    got_q.delete(); got_last.delete(); xfer_cyc.delete();
    cyc = 0; rd_pulses = 0; rd_consec = 0; rd_while_empty = 0; rd_on_last = 0;
    stall_changes = 0; last_ren_cyc = -1; first_valid_cyc = -1; err_rise_cyc = -1;
    prev_ren = 0; prev_stall = 0; prev_last = 0; prev_err = 0; prev_data = '0;
  endfunction

  function automatic int diff_count(input logic [WIDTH-1:0] exp[$]);
    int n = 0;
    if (exp.size() != got_q.size()) n++;
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp[i]) n++;
    return n;
  endfunction

  // Every J-th accepted word, and only those, closes a group.
  function automatic int last_errs();
    int n = 0;
    for (int i = 0; i < got_last.size(); i++)
      if (got_last[i] != ((i % J) == J - 1)) n++;
    return n;
  endfunction

  function automatic void add_exp(input logic [WIDTH*J-1:0] g);
    for (int s = 0; s < J; s++) exp_q.push_back(g[s*WIDTH +: WIDTH]);
  endfunction

  // One clock: drive inputs after the falling edge, sample just before the rising edge.
  task automatic cycle();
    @(negedge clk);
    bus_if.buf_empty = (grp_q.size() == 0);
    bus_if.buf_valid = 1'b0;
    if (pend == 1) begin
      bus_if.buf_valid = 1'b1;
      bus_if.buf_data  = pend_data;
    end else if (stray_valid) begin
      bus_if.buf_valid = 1'b1;
      bus_if.buf_data  = stray_data;
      stray_valid      = 0;
    end
    if (pend > 0) pend--;
    case (rdy_mode)
      0: bus_if.ser_ready = 1'b1;
      1: if (bus_if.ser_valid && rdy_q.size() > 0) bus_if.ser_ready = rdy_q.pop_front();
         else bus_if.ser_ready = 1'b1;
      default: bus_if.ser_ready = ($urandom_range(0, 3) != 0);
    endcase
    #4;
    cyc++;
    if (prev_stall && (!bus_if.ser_valid || bus_if.ser_data !== prev_data || bus_if.ser_last !== prev_last))
      stall_changes++;
    prev_stall = bus_if.ser_valid && !bus_if.ser_ready;
    prev_data  = bus_if.ser_data;
    prev_last  = bus_if.ser_last;
    if (bus_if.ser_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus_if.ser_valid && bus_if.ser_ready) begin
      got_q.push_back(bus_if.ser_data);
      got_last.push_back(bus_if.ser_last);
      xfer_cyc.push_back(cyc);
    end
    if (err_timeout && !prev_err) err_rise_cyc = cyc;
    prev_err = err_timeout;
    if (bus_if.buf_r_en) begin
      rd_pulses++;
      last_ren_cyc = cyc;
      if (bus_if.buf_empty) rd_while_empty++;
      if (prev_ren) rd_consec++;
      if (bus_if.ser_valid && bus_if.ser_ready && bus_if.ser_last) rd_on_last++;
      if (grp_q.size() > 0) begin
        pend_data = grp_q.pop_front();
        if (respond) pend = lat;
      end
    end
    prev_ren = bus_if.buf_r_en;
  endtask

  task automatic run_until(input int n, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (got_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    grp_q.delete(); exp_q.delete(); rdy_q.delete();
    pend = 0; stray_valid = 0; respond = 1; lat = 1; rdy_mode = 0;
    bus_if.buf_empty = 1'b1; bus_if.buf_valid = 1'b0; bus_if.buf_data = '0; bus_if.ser_ready = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.buf_empty = 1'b0; bus_if.buf_valid = 1'b1; bus_if.ser_ready = 1'b1;
    bus_if.buf_data  = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({bus_if.buf_r_en, bus_if.ser_valid, bus_if.ser_last, busy, err_timeout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: r_en/valid/last/busy/err=%b, want 00000",
               {bus_if.buf_r_en, bus_if.ser_valid, bus_if.ser_last, busy, err_timeout});
    end
    checks++;
    if (bus_if.ser_data !== '0 || words_out !== '0) begin
      failures++;
      $display("FAIL reset_data: ser_data=%0d words_out=%0d, want 0 0", bus_if.ser_data, words_out);
    end
    do_reset();
    repeat (4) cycle();
    checks++;
    if (busy !== 1'b0 || rd_pulses != 0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b r_en pulses=%0d, want 0 0", busy, rd_pulses);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    grp_q.push_back({8'd10, 8'd15, 8'd25, 8'd12});
    exp_q = '{8'd12, 8'd25, 8'd15, 8'd10};
    run_until(4, 60, ok);
    repeat (4) cycle();
    checks++;
    if (!ok || diff_count(exp_q) != 0) begin
      failures++;
      $display("FAIL basic_words: %0d words %0d mismatches, want 4 words 0 mismatches", got_q.size(), diff_count(exp_q));
    end
    checks++;
    if (rd_pulses != 1) begin failures++; $display("FAIL basic_r_en: %0d pulses, want 1", rd_pulses); end
    checks++;
    if (last_errs() != 0) begin failures++; $display("FAIL basic_last: %0d bad last flags, want 0", last_errs()); end
    checks++;
    if (words_out !== 16'd4) begin failures++; $display("FAIL basic_count: words_out=%0d, want 4", words_out); end
    // buf_valid one cycle after the request, first word one cycle after that
    checks++;
    if (first_valid_cyc - last_ren_cyc != 2) begin
      failures++;
      $display("FAIL basic_latency: request to first valid %0d cycles, want 2", first_valid_cyc - last_ren_cyc);
    end
    checks++;
    if (xfer_cyc.size() != 4 || xfer_cyc[3] - xfer_cyc[0] != 3) begin
      failures++;
      $display("FAIL basic_consecutive: %0d transfers not on 4 consecutive cycles", xfer_cyc.size());
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle: busy=%b, want 0", busy); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    rdy_mode = 1;
    rdy_q = '{1, 0, 0, 1, 0, 1, 1};
    grp_q.push_back({8'd10, 8'd15, 8'd25, 8'd12});
    exp_q = '{8'd12, 8'd25, 8'd15, 8'd10};
    run_until(4, 60, ok);
    repeat (3) cycle();
    checks++;
    if (!ok || diff_count(exp_q) != 0) begin
      failures++;
      $display("FAIL stall_words: %0d words %0d mismatches, want 4 words 0 mismatches", got_q.size(), diff_count(exp_q));
    end
    checks++;
    if (stall_changes != 0) begin failures++; $display("FAIL stall_hold: %0d changes while stalled, want 0", stall_changes); end
    checks++;
    if (words_out !== 16'd4) begin failures++; $display("FAIL stall_count: words_out=%0d, want 4", words_out); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    grp_q.push_back({8'd1, 8'd2, 8'd3, 8'd4});
    grp_q.push_back({8'd5, 8'd6, 8'd7, 8'd8});
    exp_q = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5};
    run_until(8, 80, ok);
    repeat (3) cycle();
    checks++;
    if (!ok || diff_count(exp_q) != 0) begin
      failures++;
      $display("FAIL b2b_words: %0d words %0d mismatches, want 8 words 0 mismatches", got_q.size(), diff_count(exp_q));
    end
    checks++;
    if (rd_pulses != 2 || rd_on_last != 1) begin
      failures++;
      $display("FAIL b2b_r_en: pulses=%0d on_last=%0d, want 2 1", rd_pulses, rd_on_last);
    end
    checks++;
    if (words_out !== 16'd8) begin failures++; $display("FAIL b2b_count: words_out=%0d, want 8", words_out); end
    checks++;
    if (last_errs() != 0 || rd_consec != 0) begin
      failures++;
      $display("FAIL b2b_flags: bad last=%0d consecutive r_en=%0d, want 0 0", last_errs(), rd_consec);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    respond = 0;
    grp_q.push_back({$urandom});
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (err_rise_cyc >= 0) break;
    end
    // Request is registered at the edge closing its cycle; the flag lands TIMEOUT edges later.
    checks++;
    if (err_rise_cyc < 0 || err_rise_cyc - last_ren_cyc != TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_time: err rise at sample %0d, request at %0d, want distance %0d",
               err_rise_cyc, last_ren_cyc, TIMEOUT + 1);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: busy=%b, want 0", busy); end
    repeat (3) cycle();
    respond = 1;
    grp_q.push_back({8'd40, 8'd30, 8'd20, 8'd10});
    exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_until(4, 60, ok);
    repeat (2) cycle();
    checks++;
    if (rd_pulses != 2) begin failures++; $display("FAIL timeout_retry: %0d pulses, want 2", rd_pulses); end
    checks++;
    if (!ok || diff_count(exp_q) != 0) begin
      failures++;
      $display("FAIL timeout_words: %0d words %0d mismatches, want 4 words 0 mismatches", got_q.size(), diff_count(exp_q));
    end
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky: err=%b, want 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    grp_q.push_back({$urandom});
    run_until(2, 60, ok);
    @(posedge clk);
    #2;
    checks++;
    if (!ok || words_out !== 16'd2 || bus_if.ser_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: words_out=%0d valid=%b, want 2 1", words_out, bus_if.ser_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.ser_valid !== 1'b0 || busy !== 1'b0 || words_out !== '0) begin
      failures++;
      $display("FAIL midrst_async: valid=%b busy=%b words_out=%0d, want 0 0 0", bus_if.ser_valid, busy, words_out);
    end
    grp_q.delete(); pend = 0;
    repeat (2) cycle();
    rst = 1'b1;
    rd_pulses = 0;
    repeat (6) cycle();
    checks++;
    if (rd_pulses != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: r_en pulses=%0d busy=%b, want 0 0", rd_pulses, busy);
    end
  endtask

  task automatic test_ignore_valid();
    bit ok;
    logic [WIDTH*J-1:0] g;
    do_reset();
    stray_valid = 1;
    stray_data  = {$urandom};
    repeat (5) cycle();
    checks++;
    if (first_valid_cyc >= 0 || busy !== 1'b0 || rd_pulses != 0) begin
      failures++;
      $display("FAIL stray_valid: valid seen at %0d busy=%b pulses=%0d, want -1 0 0", first_valid_cyc, busy, rd_pulses);
    end
    g = {$urandom};
    grp_q.push_back(g);
    add_exp(g);
    run_until(4, 60, ok);
    checks++;
    if (!ok || diff_count(exp_q) != 0) begin
      failures++;
      $display("FAIL stray_words: %0d words %0d mismatches, want 4 words 0 mismatches", got_q.size(), diff_count(exp_q));
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    logic [WIDTH*J-1:0] g;
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if (pushed < 10 && $urandom_range(0, 3) == 0) begin
        g = {$urandom};
        grp_q.push_back(g);
        add_exp(g);
        pushed++;
      end
      lat = $urandom_range(1, 4);
      cycle();
      if (got_q.size() >= 10 * J) break;
    end
    repeat (3) cycle();
    checks++;
    if (diff_count(exp_q) != 0) begin
      failures++;
      $display("FAIL rand_words: %0d words %0d mismatches, want %0d words 0 mismatches", got_q.size(), diff_count(exp_q), 10 * J);
    end
    checks++;
    if (last_errs() != 0 || stall_changes != 0) begin
      failures++;
      $display("FAIL rand_flags: bad last=%0d stall changes=%0d, want 0 0", last_errs(), stall_changes);
    end
    checks++;
    if (words_out !== CNT_W'(10 * J)) begin failures++; $display("FAIL rand_count: words_out=%0d, want %0d", words_out, 10 * J); end
    checks++;
    if (rd_pulses != 10 || rd_consec != 0 || rd_while_empty != 0) begin
      failures++;
      $display("FAIL rand_r_en: pulses=%0d consecutive=%0d while_empty=%0d, want 10 0 0", rd_pulses, rd_consec, rd_while_empty);
    end
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL rand_err: err=%b, want 0", err_timeout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_ignore_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/par_to_ser_unloader.md
Name: par_to_ser_unloader

Overview:
- Downstream consumer of the multi-in/multi-out circular buffer.
- Requests one J-word group from the buffer's read side and latches it.
- Streams the group out one WIDTH-bit word per cycle on a valid/ready interface, flagging the last word of each group.
- Feeds the serial datapath that follows the buffer.

Parameters:
WIDTH, 8, bits per word
J, 4, words per buffer read group (must match buffer J)
TIMEOUT, 16, max cycles to wait for buf_valid after a request
CNT_W, 16, width of emitted-word counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
buf_empty  input  1  buffer empty flag
buf_valid  input  1  buffer read data valid
buf_data  input  WIDTH*J  buffer parallel read data; slot i = bits [i*WIDTH +: WIDTH]
buf_r_en  output  1  read request to buffer, single-cycle pulse
ser_data  output  WIDTH  serial word out
ser_valid  output  1  ser_data valid
ser_ready  input  1  downstream accepts word
ser_last  output  1  current word is slot J-1 of its group
busy  output  1  state != IDLE
err_timeout  output  1  sticky: a request timed out
words_out  output  CNT_W  count of accepted serial words, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, async): state=IDLE, idx=0, hold=0, timer=0. All outputs 0: buf_r_en, ser_valid, ser_last, ser_data, busy, err_timeout, words_out. Release is synchronous to the next clk edge.
- States: IDLE, WAIT, SHIFT.
- IDLE:
  - buf_empty=0 -> assert buf_r_en for exactly this cycle; timer=0; next WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - buf_r_en=0; timer increments each cycle.
  - buf_valid=1 -> hold<=buf_data, idx<=0, next SHIFT.
  - If buf_valid does not arrive by timer==TIMEOUT-1: set err_timeout (sticky until reset), next IDLE.
  - buf_valid on the same cycle as the timeout expiry: data wins; capture and go to SHIFT, err_timeout not set.
- SHIFT:
  - ser_valid=1; ser_data=hold[idx]; ser_last=(idx==J-1).
  - Slot 0 (LSBs of buf_data) is sent first.
  - Handshake: a transfer occurs when ser_valid&&ser_ready. Each transfer increments words_out by 1.
  - ser_data and ser_last hold stable while ser_valid=1 and ser_ready=0. No word is dropped or duplicated.
  - Transfer with idx<J-1 -> idx+1.
  - Transfer with idx==J-1 and buf_empty=0 -> assert buf_r_en in that same cycle, next WAIT (back-to-back groups: one-bubble minimum for 1-cycle buffer latency).
  - Transfer with idx==J-1 and buf_empty=1 -> next IDLE.
- buf_valid in IDLE or SHIFT is ignored; hold is not modified.
- buf_r_en is never asserted while buf_empty=1 and never on two consecutive cycles.
- ser_valid is registered: low in IDLE/WAIT, high the cycle after entering SHIFT. Latency from buf_valid to first ser_valid is 1 cycle.
- Reset mid-group: group discarded, outputs return to reset values immediately, no further buf_r_en until buf_empty=0 after release.
- words_out wraps from 2^CNT_W-1 to 0 without error.

Decomposition:
- Shared package (buffer/unloader package):
  - State enum {IDLE, WAIT, SHIFT}.
  - Slice helper function: word index -> WIDTH-bit slice.
  - Default WIDTH/J constants shared with the buffer top.
- One natural sub-module: par_shift_hold.
  - J-word load register with index mux and last flag.
  - Interface: load, advance, idx, data, last.
- FSM, timer and counters stay in par_to_ser_unloader.

Test Plan:
- Reset, then buf_empty=0, buf_data={8'd10,8'd15,8'd25,8'd12}, buf_valid 1 cycle after buf_r_en, ser_ready=1:
  - exactly one buf_r_en pulse;
  - ser_data sequence 12,25,15,10 on consecutive cycles;
  - ser_last only on 10;
  - words_out=4.
- Same data with ser_ready toggling 1,0,0,1,0,1,1:
  - each word held stable while stalled;
  - order 12,25,15,10;
  - no duplicates;
  - words_out=4.
- buf_empty held 0 for two groups {1,2,3,4} then {5,6,7,8}:
  - second buf_r_en coincides with the transfer of word 4;
  - serial output 4,3,2,1,8,7,6,5;
  - words_out=8.
- buf_valid never returned after a request, TIMEOUT=16:
  - err_timeout rises 16 cycles after buf_r_en;
  - FSM returns to IDLE;
  - next buf_empty=0 triggers a new buf_r_en;
  - err_timeout stays 1.
- rst driven low after 2 words of a group:
  - ser_valid, busy and words_out drop to 0 asynchronously;
  - after release with buf_empty=1, buf_r_en stays 0.
- buf_valid pulsed in IDLE with buf_empty=1:
  - no capture, ser_valid stays 0, busy stays 0.
